// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) doubling, key-length
// decoding and the key-schedule engine's state encoding.
package aes_pkg;

   localparam int RK_WIDTH  = 128;
   localparam int MAX_WORDS = 60;

   typedef enum logic [1:0] {
      KL128 = 2'd0,
      KL192 = 2'd1,
      KL256 = 2'd2
   } key_len_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_READY  = 2'd2
   } ks_state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8) with the AES polynomial (0x80 -> 0x1B)
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Key length in 32-bit words; 0 marks the reserved encoding
   function automatic logic [3:0] nk_of(input logic [1:0] kl);
      case (kl)
         KL128:   nk_of = 4'd4;
         KL192:   nk_of = 4'd6;
         KL256:   nk_of = 4'd8;
         default: nk_of = 4'd0;
      endcase
   endfunction

   // Number of cipher rounds; 0 marks the reserved encoding
   function automatic logic [3:0] nr_of(input logic [1:0] kl);
      case (kl)
         KL128:   nr_of = 4'd10;
         KL192:   nr_of = 4'd12;
         KL256:   nr_of = 4'd14;
         default: nr_of = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word. Purely
// combinational so the cipher's SubBytes stage can reuse it.
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   // Substitute each byte independently through the S-box
   always_comb begin
      word_o = 32'h0000_0000;
      for (int b = 0; b < 4; b++) begin
         word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
      end
   end

endmodule

// File: rtl/aes_key_schedule_engine.sv
// Sequential AES-128/192/256 key expansion. One schedule word is produced
// per cycle into a word store; round keys are read back through a
// registered, index-addressed port.
module aes_key_schedule_engine
   import aes_pkg::*;
#(
   parameter int MAX_KEY_WIDTH = 256
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [1:0]               key_len,
   input  logic [MAX_KEY_WIDTH-1:0] key_in,
   output logic                     busy,
   output logic                     done,
   output logic                     key_valid,
   output logic [3:0]               num_rounds,
   output logic                     cfg_err,
   input  logic                     rk_rd_en,
   input  logic [3:0]               rk_rd_idx,
   output logic [RK_WIDTH-1:0]      round_key,
   output logic                     rk_rd_valid,
   output logic                     rk_rd_err
);

   localparam int MAX_NK      = MAX_KEY_WIDTH / 32;
   localparam int STORE_DEPTH = 4 * (MAX_NK + 7);

   // Control state
   ks_state_e            state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 key_valid_q, key_valid_d;
   logic [3:0]           num_rounds_q, num_rounds_d;
   logic                 cfg_err_q, cfg_err_d;
   logic [5:0]           i_q, i_d;
   logic [2:0]           phase_q, phase_d;
   logic [7:0]           rcon_q, rcon_d;
   logic [3:0]           nk_q, nk_d;
   logic [3:0]           nr_q, nr_d;
   logic [5:0]           last_q, last_d;
   logic [RK_WIDTH-1:0]  round_key_q, round_key_d;
   logic                 rk_rd_valid_q, rk_rd_valid_d;
   logic                 rk_rd_err_q, rk_rd_err_d;

   // Word store (contents are don't-care until a schedule is built)
   logic [31:0]          w_q [STORE_DEPTH];

   // Start decode
   logic [3:0]           start_nk_s;
   logic [3:0]           start_nr_s;
   logic                 key_len_ok_s;
   logic                 start_accept_s;
   logic                 start_reject_s;

   // Expansion datapath
   logic [5:0]           prev_idx_s;
   logic [5:0]           back_idx_s;
   logic [31:0]          prev_word_s;
   logic [31:0]          back_word_s;
   logic [31:0]          sub_in_s;
   logic [31:0]          sub_out_s;
   logic [31:0]          temp_s;
   logic [31:0]          new_word_s;
   logic                 load_s;
   logic                 wr_en_s;

   // Read datapath
   logic                 rd_ok_s;
   logic [5:0]           rd_base_s;
   logic [RK_WIDTH-1:0]  rd_data_s;

   aes_subword u_subword (
      .word_i (sub_in_s),
      .word_o (sub_out_s)
   );

   // Decode requested key length and decide whether a start is taken
   always_comb begin
      start_nk_s     = nk_of(key_len);
      start_nr_s     = nr_of(key_len);
      key_len_ok_s   = (key_len <= 2'd2) && (int'(start_nk_s) <= MAX_NK);
      start_accept_s = start && !busy_q && key_len_ok_s;
      start_reject_s = start && !busy_q && !key_len_ok_s;
   end

   // Next schedule word: w[i] = w[i-Nk] ^ f(w[i-1]); phase tracks i mod Nk
   always_comb begin
      prev_idx_s  = i_q - 6'd1;
      back_idx_s  = i_q - {2'b00, nk_q};
      prev_word_s = w_q[prev_idx_s];
      back_word_s = w_q[back_idx_s];
      if (phase_q == 3'd0) begin
         sub_in_s = {prev_word_s[23:0], prev_word_s[31:24]};
      end else begin
         sub_in_s = prev_word_s;
      end
      if (phase_q == 3'd0) begin
         temp_s = sub_out_s ^ {rcon_q, 24'h00_0000};
      end else if ((nk_q == 4'd8) && (phase_q == 3'd4)) begin
         temp_s = sub_out_s;
      end else begin
         temp_s = prev_word_s;
      end
      new_word_s = back_word_s ^ temp_s;
   end

   // FSM next state, expansion counters and status outputs
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      key_valid_d  = key_valid_q;
      num_rounds_d = num_rounds_q;
      cfg_err_d    = 1'b0;
      i_d          = i_q;
      phase_d      = phase_q;
      rcon_d       = rcon_q;
      nk_d         = nk_q;
      nr_d         = nr_q;
      last_d       = last_q;
      load_s       = 1'b0;
      wr_en_s      = 1'b0;
      case (state_q)
         ST_IDLE, ST_READY: begin
            if (start_accept_s) begin
               load_s       = 1'b1;
               key_valid_d  = 1'b0;
               num_rounds_d = 4'd0;
               i_d          = {2'b00, start_nk_s};
               phase_d      = 3'd0;
               rcon_d       = 8'h01;
               nk_d         = start_nk_s;
               nr_d         = start_nr_s;
               // Index of the final word: 4*(Nr+1)-1
               last_d       = {start_nr_s, 2'b00} + 6'd3;
               state_d      = ST_EXPAND;
               busy_d       = 1'b1;
            end else if (start_reject_s) begin
               cfg_err_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_EXPAND: begin
            wr_en_s = 1'b1;
            if (phase_q == 3'd0) begin
               rcon_d = xtime(rcon_q);
            end else begin
               rcon_d = rcon_q;
            end
            if (i_q == last_q) begin
               // Hold i so the store read addresses stay in range while idle
               state_d      = ST_READY;
               busy_d       = 1'b0;
               done_d       = 1'b1;
               key_valid_d  = 1'b1;
               num_rounds_d = nr_q;
            end else begin
               i_d = i_q + 6'd1;
               if ({1'b0, phase_q} == (nk_q - 4'd1)) begin
                  phase_d = 3'd0;
               end else begin
                  phase_d = phase_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Round-key read: an accepted start in the same cycle counts as no schedule
   always_comb begin
      rd_ok_s       = key_valid_q && !start_accept_s && (rk_rd_idx <= num_rounds_q);
      rd_base_s     = rd_ok_s ? {rk_rd_idx, 2'b00} : 6'd0;
      rd_data_s     = {w_q[rd_base_s], w_q[rd_base_s + 6'd1],
                       w_q[rd_base_s + 6'd2], w_q[rd_base_s + 6'd3]};
      rk_rd_valid_d = rk_rd_en;
      if (rk_rd_en) begin
         if (rd_ok_s) begin
            round_key_d = rd_data_s;
            rk_rd_err_d = 1'b0;
         end else begin
            round_key_d = '0;
            rk_rd_err_d = 1'b1;
         end
      end else begin
         round_key_d = round_key_q;
         rk_rd_err_d = 1'b0;
      end
   end

   // Control and read-port registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         key_valid_q   <= 1'b0;
         num_rounds_q  <= 4'd0;
         cfg_err_q     <= 1'b0;
         i_q           <= 6'd8;
         phase_q       <= 3'd0;
         rcon_q        <= 8'h01;
         nk_q          <= 4'd4;
         nr_q          <= 4'd10;
         last_q        <= 6'd43;
         round_key_q   <= '0;
         rk_rd_valid_q <= 1'b0;
         rk_rd_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         key_valid_q   <= key_valid_d;
         num_rounds_q  <= num_rounds_d;
         cfg_err_q     <= cfg_err_d;
         i_q           <= i_d;
         phase_q       <= phase_d;
         rcon_q        <= rcon_d;
         nk_q          <= nk_d;
         nr_q          <= nr_d;
         last_q        <= last_d;
         round_key_q   <= round_key_d;
         rk_rd_valid_q <= rk_rd_valid_d;
         rk_rd_err_q   <= rk_rd_err_d;
      end
   end

   // Word store: bulk key load on accepted start, one expanded word per EXPAND cycle
   always_ff @(posedge clk) begin
      if (load_s) begin
         for (int k = 0; k < MAX_NK; k++) begin
            w_q[k] <= key_in[MAX_KEY_WIDTH-1-32*k -: 32];
         end
      end else if (wr_en_s) begin
         w_q[i_q] <= new_word_s;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign key_valid   = key_valid_q;
   assign num_rounds  = num_rounds_q;
   assign cfg_err     = cfg_err_q;
   assign round_key   = round_key_q;
   assign rk_rd_valid = rk_rd_valid_q;
   assign rk_rd_err   = rk_rd_err_q;

endmodule
